// File: rtl/uranus_mem_pkg.sv
// rtl/uranus_mem_pkg.sv - shared types and constants for the memory stall bridge
package uranus_mem_pkg;

    typedef enum logic [1:0] {
        MB_IDLE  = 2'd0,
        MB_ISSUE = 2'd1,
        MB_WAIT  = 2'd2,
        MB_DONE  = 2'd3
    } mb_state_t;

    typedef enum logic {
        SEL_INST = 1'b0,
        SEL_DATA = 1'b1
    } mb_sel_t;

    // Byte-offset bits cleared to form a word-aligned bus address
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_stall_bridge.sv
// rtl/mem_stall_bridge.sv - merges fetch and data ports onto one stalling memory bus
module mem_stall_bridge
    import uranus_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rom_en,
    input  logic [ADDR_WIDTH-1:0]   rom_addr,
    output logic [DATA_WIDTH-1:0]   rom_read_data,
    input  logic                    ram_en,
    input  logic [DATA_WIDTH/8-1:0] ram_write_en,
    input  logic [ADDR_WIDTH-1:0]   ram_addr,
    input  logic [DATA_WIDTH-1:0]   ram_write_data,
    output logic [DATA_WIDTH-1:0]   ram_read_data,
    output logic                    stall_all,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_CLEAR = ~{{(ADDR_WIDTH-2){1'b0}}, WORD_ALIGN_MASK};

    mb_state_t             state;
    mb_state_t             state_next;
    logic                  pend_d;
    logic                  pend_i;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [BE_WIDTH-1:0]   ram_we_q;
    logic [DATA_WIDTH-1:0] ram_wdata_q;
    mb_sel_t               sel;
    logic                  req_any;
    logic                  rsp_take;

    assign req_any  = rom_en | ram_en;
    // Data access always wins while it is still pending
    assign sel      = pend_d ? SEL_DATA : SEL_INST;
    // Responses only count while waiting; rvalid in IDLE/ISSUE/DONE is noise
    assign rsp_take = (state == MB_WAIT) && mem_rvalid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, core stall and bus request mux
    always_comb begin
        state_next = state;
        stall_all  = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_we     = '0;
        mem_wdata  = '0;
        case (state)
            MB_IDLE: begin
                stall_all = req_any;
                if (req_any) begin
                    state_next = MB_ISSUE;
                end
            end
            MB_ISSUE: begin
                stall_all = 1'b1;
                mem_req   = 1'b1;
                if (sel == SEL_DATA) begin
                    mem_addr  = ram_addr_q & ALIGN_CLEAR;
                    mem_we    = ram_we_q;
                    mem_wdata = ram_wdata_q;
                end else begin
                    mem_addr  = rom_addr_q & ALIGN_CLEAR;
                end
                if (mem_gnt) begin
                    state_next = MB_WAIT;
                end
            end
            MB_WAIT: begin
                stall_all = 1'b1;
                if (mem_rvalid) begin
                    // A fetch is only served after the data access, so only a
                    // finished data access can leave a fetch behind
                    state_next = (sel == SEL_DATA && pend_i) ? MB_ISSUE : MB_DONE;
                end
            end
            MB_DONE: begin
                // Core advances on this edge; its enables still show the old request
                state_next = MB_IDLE;
            end
            default: begin
                state_next = MB_IDLE;
            end
        endcase
    end

    // Capture the core request in IDLE and retire pending flags on each response
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_d      <= 1'b0;
            pend_i      <= 1'b0;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= '0;
            ram_wdata_q <= '0;
        end else if (state == MB_IDLE && req_any) begin
            pend_d      <= ram_en;
            pend_i      <= rom_en;
            rom_addr_q  <= rom_addr;
            ram_addr_q  <= ram_addr;
            ram_we_q    <= ram_write_en;
            ram_wdata_q <= ram_write_data;
        end else if (rsp_take) begin
            if (sel == SEL_DATA) begin
                pend_d <= 1'b0;
            end else begin
                pend_i <= 1'b0;
            end
        end
    end

    // Read-data registers hold until the next read of their own port
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_read_data <= '0;
            ram_read_data <= '0;
        end else if (rsp_take) begin
            if (sel == SEL_DATA) begin
                if (ram_we_q == '0) begin
                    ram_read_data <= mem_rdata;
                end
            end else begin
                rom_read_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stall_bridge.sv
// tb/tb_mem_stall_bridge.sv - scoreboard bench for mem_stall_bridge
module tb_mem_stall_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_read_data;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        stall_all;
    logic        mem_req;
    logic        mem_gnt;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gd;
        int          rd;
        bit          noise;
    } txn_t;

    txn_t        bus_q[$];
    txn_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          agent_en = 1'b0;
    bit          in_done = 1'b0;
    logic [31:0] exp_rom = '0;
    logic [31:0] exp_ram = '0;

    always #5 clk = ~clk;

    mem_stall_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_read_data  (rom_read_data),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data),
        .stall_all      (stall_all),
        .mem_req        (mem_req),
        .mem_gnt        (mem_gnt),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Bus agent: grant/response delays come from the transaction the stimulus queued
    initial begin
        txn_t t;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            while (agent_en && mem_req && bus_q.size() > 0) begin
                t = bus_q.pop_front();
                repeat (t.gd) @(negedge clk);
                mem_gnt = 1'b1;
                if (t.noise) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = ~t.rdata;
                end
                @(negedge clk);
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                repeat (t.rd) @(negedge clk);
                mem_rvalid = 1'b1;
                mem_rdata  = t.rdata;
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
        end
    end

    // Monitor: every requesting cycle must match the head of the expected queue
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected_req actual=%0h expected=no request", mem_addr);
                end else begin
                    chk("bus_addr", mem_addr, {exp_q[0].addr[31:2], 2'b00});
                    chk("bus_we", {28'd0, mem_we}, {28'd0, exp_q[0].we});
                    if (exp_q[0].we != 4'd0) chk("bus_wdata", mem_wdata, exp_q[0].wdata);
                    if (mem_gnt) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One core request; bus order is data first, then fetch.
    // Stall length = IDLE cycle + per transaction (grant wait+1) + (response wait+1).
    task automatic access(input bit i_en, input logic [31:0] i_addr, input logic [31:0] i_rdata,
                          input bit d_en, input logic [31:0] d_addr, input logic [3:0] d_we,
                          input logic [31:0] d_wdata, input logic [31:0] d_rdata,
                          input int gd, input int rd, input bit noise);
        txn_t t;
        int   exp_n;
        int   n;
        exp_n          = 1;
        rom_en         = i_en;
        rom_addr       = i_addr;
        ram_en         = d_en;
        ram_write_en   = d_we;
        ram_addr       = d_addr;
        ram_write_data = d_wdata;
        if (d_en) begin
            t.addr = d_addr; t.we = d_we; t.wdata = d_wdata; t.rdata = d_rdata;
            t.gd = (gd < 0) ? int'($urandom_range(0, 3)) : gd;
            t.rd = (rd < 0) ? int'($urandom_range(0, 3)) : rd;
            t.noise = noise;
            bus_q.push_back(t);
            exp_q.push_back(t);
            exp_n += t.gd + t.rd + 2;
            if (d_we == 4'd0) exp_ram = d_rdata;
        end
        if (i_en) begin
            t.addr = i_addr; t.we = 4'd0; t.wdata = '0; t.rdata = i_rdata;
            t.gd = (gd < 0) ? int'($urandom_range(0, 3)) : gd;
            t.rd = (rd < 0) ? int'($urandom_range(0, 3)) : rd;
            t.noise = noise;
            bus_q.push_back(t);
            exp_q.push_back(t);
            exp_n += t.gd + t.rd + 2;
            exp_rom = i_rdata;
        end
        if (in_done) begin
            @(posedge clk);
            #1;
            chk("idle_after_done_stall", {31'd0, stall_all}, 32'd1);
            chk("idle_after_done_req", {31'd0, mem_req}, 32'd0);
        end else begin
            #1;
        end
        n = 0;
        while (stall_all === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("stall_cycles", n, exp_n);
        chk("rom_read_data", rom_read_data, exp_rom);
        chk("ram_read_data", ram_read_data, exp_ram);
        @(negedge clk);
        in_done = 1'b1;
    endtask

    task automatic idle(input int k);
        rom_en = 1'b0;
        ram_en = 1'b0;
        repeat (k) begin
            #1;
            chk("idle_stall", {31'd0, stall_all}, 32'd0);
            @(negedge clk);
        end
        in_done = 1'b0;
    endtask

    initial begin
        txn_t        t;
        logic [31:0] ra;
        logic [31:0] da;
        logic [3:0]  we;
        bit          ie;
        bit          de;
        rst = 1'b1;
        rom_en = 1'b0; rom_addr = '0;
        ram_en = 1'b0; ram_write_en = '0; ram_addr = '0; ram_write_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rom_read_data", rom_read_data, 32'd0);
        chk("rst_ram_read_data", ram_read_data, 32'd0);
        chk("rst_stall", {31'd0, stall_all}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        agent_en = 1'b1;
        in_done  = 1'b0;

        // Fetch only, zero-latency bus
        access(1'b1, 32'hBFC0_0004, 32'h2402_0001, 1'b0, '0, 4'd0, '0, '0, 0, 0, 1'b0);
        idle(2);
        // Store plus fetch together
        access(1'b1, 32'hBFC0_0008, 32'h3C01_8000, 1'b1, 32'h8000_0102, 4'b0011, 32'h0000_BEEF,
               32'h5555_AAAA, 0, 0, 1'b0);
        idle(1);
        // Wait states: grant after 3 low cycles, response 2 cycles after grant
        access(1'b0, '0, '0, 1'b1, 32'h8000_0200, 4'd0, '0, 32'hDEAD_BEEF, 3, 1, 1'b0);
        idle(1);

        // Reset while in WAIT, then a stale response
        agent_en = 1'b0;
        ram_en = 1'b1; ram_write_en = 4'd0; ram_addr = 32'h8000_0040;
        t.addr = 32'h8000_0040; t.we = 4'd0; t.wdata = '0; t.rdata = '0; t.gd = 0; t.rd = 0; t.noise = 1'b0;
        exp_q.push_back(t);
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        ram_en  = 1'b0;
        @(negedge clk);
        #1;
        chk("wait_req", {31'd0, mem_req}, 32'd0);
        chk("wait_stall", {31'd0, stall_all}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rom = '0;
        exp_ram = '0;
        #1;
        chk("rstwait_req", {31'd0, mem_req}, 32'd0);
        chk("rstwait_stall", {31'd0, stall_all}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("stale_ram_read_data", ram_read_data, exp_ram);
        chk("stale_rom_read_data", rom_read_data, exp_rom);
        @(negedge clk);
        // Reset while in ISSUE must withdraw the request at that edge
        ram_en = 1'b1; ram_addr = 32'h8000_0080;
        t.addr = 32'h8000_0080;
        exp_q.push_back(t);
        @(negedge clk);
        #1;
        chk("issue_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        ram_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstissue_req", {31'd0, mem_req}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        agent_en = 1'b1;
        in_done  = 1'b0;
        // A load straight after the stale response: DUT must be in IDLE, not DONE
        access(1'b0, '0, '0, 1'b1, 32'h8000_0300, 4'd0, '0, 32'hCAFE_F00D, 1, 0, 1'b0);

        // Back-to-back loads with enables held across DONE
        access(1'b0, '0, '0, 1'b1, 32'h8000_0304, 4'd0, '0, 32'h0BAD_F00D, 0, 0, 1'b0);
        access(1'b0, '0, '0, 1'b1, 32'h8000_0308, 4'd0, '0, 32'h1357_9BDF, 0, 0, 1'b1);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            ie = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            if (!ie && !de) de = 1'b1;
            ra = $urandom;
            da = $urandom;
            we = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            access(ie, ra, $urandom, de, da, we, $urandom, $urandom, -1, -1,
                   ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle(1 + int'($urandom_range(0, 2)));
        end
        idle(2);
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog actual=timeout expected=completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stall_bridge.md
# mem_stall_bridge

Merges the CPU's instruction-fetch port (rom_*) and data port (ram_*) onto a single variable-latency memory bus, holding the core with `stall_all` while accesses are outstanding. Sits between the `Uranus` core and the memory subsystem, replacing the fixed one-cycle ROM/RAM models once real memory with wait states is attached. Only one bus transaction is in flight at a time. Data accesses take priority over the fetch.

## Interface
- `ADDR_WIDTH`, default 32: address width on both sides.
- `DATA_WIDTH`, default 32: data width. Byte-enable width is `DATA_WIDTH/8`.
- `clk`, input, 1: the single clock. All logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rom_en`, input, 1: fetch request from the core.
- `rom_addr`, input, ADDR_WIDTH: fetch address.
- `rom_read_data`, output, DATA_WIDTH: fetched word.
- `ram_en`, input, 1: data request from the core.
- `ram_write_en`, input, DATA_WIDTH/8: byte write enables. Zero means a read.
- `ram_addr`, input, ADDR_WIDTH: data address.
- `ram_write_data`, input, DATA_WIDTH: store data.
- `ram_read_data`, output, DATA_WIDTH: load data.
- `stall_all`, output, 1: freezes the core.
- `mem_req`, output, 1: bus request.
- `mem_gnt`, input, 1: request accepted in any cycle where `mem_req` and `mem_gnt` are both high.
- `mem_we`, output, DATA_WIDTH/8: byte enables. All zero means a read.
- `mem_addr`, output, ADDR_WIDTH: word-aligned address.
- `mem_wdata`, output, DATA_WIDTH: write data.
- `mem_rvalid`, input, 1: response. Carries read data, or acknowledges a write.
- `mem_rdata`, input, DATA_WIDTH: read data.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - `stall_all = rom_en | ram_en`, combinational.
  - If either enable is set, latch the pending flags (`pend_d = ram_en`, `pend_i = rom_en`) plus the addresses, `ram_write_en` and `ram_write_data`, then go to ISSUE.
  - `mem_rvalid` is ignored.
- **ISSUE**
  - `stall_all = 1` and `mem_req = 1`.
  - The data access is selected if `pend_d` is set, otherwise the fetch.
  - `mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}`.
  - `mem_we` is the latched byte enables for data, and 0 for a fetch.
  - `mem_addr`, `mem_we` and `mem_wdata` stay stable until the grant.
  - On `mem_gnt`, go to WAIT.
  - `mem_rvalid` is ignored.
- **WAIT**
  - `stall_all = 1` and `mem_req = 0`.
  - On `mem_rvalid`:
    - data read: capture `mem_rdata` into `ram_read_data`;
    - fetch: capture `mem_rdata` into `rom_read_data`;
    - write: no data capture.
  - Clear the served pending flag. If the other flag is still set, go to ISSUE; otherwise go to DONE.
- **DONE**
  - `stall_all = 0` for exactly one cycle, so the core advances at this edge.
  - Enables are ignored, because they still show the request just served.
  - Next state is IDLE.
- Read-data registers hold their value until overwritten by a later capture. A write never changes `ram_read_data`.

## Timing
- Reset values:
  - state is IDLE;
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are 0;
  - `rom_read_data` and `ram_read_data` are 0;
  - pending flags are 0.
  - `stall_all` follows the IDLE rule.
- Best case, single access with `mem_gnt` high in ISSUE and `mem_rvalid` in the first WAIT cycle: IDLE, ISSUE, WAIT, DONE. That is 4 cycles with `stall_all` high for 3.
- Both ports requested: the data transaction completes before the fetch is issued. Best case is 6 cycles.
- Every extra cycle of grant or response delay adds one stall cycle. There is no timeout.
- Reset mid-transaction:
  - forces IDLE and drops `mem_req` at the reset edge;
  - a `mem_rvalid` arriving after reset lands in IDLE and is discarded;
  - the bus agent must not grant a request that was withdrawn.
- `mem_gnt` and `mem_rvalid` in the same cycle while in ISSUE: only the grant is taken. Responses are accepted only in WAIT.

## Structure
- Shared package `uranus_mem_pkg`:
  - the state enum (`MB_IDLE`, `MB_ISSUE`, `MB_WAIT`, `MB_DONE`);
  - a port-select constant (`SEL_INST`, `SEL_DATA`);
  - the word-alignment mask.
- Single flat module. No sub-module is warranted; the request mux is a few lines inside the FSM.

## Test plan
- Fetch only: `rom_en = 1`, `rom_addr = 0xBFC0_0004`, zero-latency bus returning `0x2402_0001`.
  - `mem_addr = 0xBFC0_0004` and `mem_we = 0` in ISSUE.
  - `stall_all` is 1,1,1,0.
  - `rom_read_data = 0x2402_0001` from DONE onward.
- Store plus fetch together: `ram_write_en = 4'b0011`, `ram_addr = 0x8000_0102`, `ram_write_data = 0x0000_BEEF`.
  - The first request is `mem_addr = 0x8000_0100`, `mem_we = 0x3`; the second is the fetch.
  - DONE occurs 6 cycles after the request.
  - `ram_read_data` is unchanged.
- Wait states: `mem_gnt` held low for 3 cycles, then `mem_rvalid` 2 cycles after the grant, on a load returning `0xDEAD_BEEF`.
  - `stall_all` stays high for 7 consecutive cycles.
  - `ram_read_data = 0xDEAD_BEEF`.
- Reset in WAIT: assert `rst` for one cycle, then drive `mem_rvalid = 1` with `0x1234_5678`.
  - State is IDLE and `mem_req = 0`.
  - Read data stays 0.
  - No transition to DONE.
- Back-to-back: two loads with enables held high across DONE.
  - Exactly one `stall_all = 0` cycle between the two transactions.
  - The second address is issued only after the IDLE cycle.
